// File: rtl/ref_fetch_unit.sv
`default_nettype none
// ref_fetch_unit: splits reference fetch commands into 4 KB-safe read bursts
// and streams the returned beats out, in order, through a credit-protected FIFO.
module ref_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic [15:0]           cmd_words_in,
  input  logic [ID_WIDTH-1:0]   cmd_id_in,
  input  logic                  cmd_valid_in,
  output logic                  cmd_rdy_out,
  output logic [ID_WIDTH-1:0]   rd_id_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  output logic [7:0]            rd_len_out,
  output logic                  rd_info_valid_out,
  input  logic                  rd_info_rdy_in,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  input  logic                  rd_data_valid_in,
  output logic                  rd_data_rdy_out,
  output logic [DATA_WIDTH-1:0] ref_data_out,
  output logic                  ref_last_out,
  output logic                  ref_valid_out,
  input  logic                  ref_rdy_in,
  output logic                  busy_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic [ADDR_WIDTH-1:0] ptr_addr;
  logic [ADDR_WIDTH-1:0] ptr_addr_nxt;
  logic [15:0]           ptr_rem;
  logic [15:0]           ptr_rem_nxt;
  logic [15:0]           cmd_words;
  logic [15:0]           out_count;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      outstanding_nxt;

  logic                  cmd_take;
  logic                  issue_fire;
  logic                  out_fire;
  logic                  load_req;
  logic                  credit_ok;
  logic [8:0]            req_beats;
  logic [8:0]            next_len;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_wr;
  logic                  fifo_rd;

  // Burst length limited by remaining words, MAX_BURST and the distance to the
  // next 4 KB page (128 beats of 32 bytes per page).
  function automatic logic [8:0] calc_len(input logic [6:0] blk, input logic [15:0] rem);
    logic [8:0] len;
    logic [8:0] bnd;
    bnd = 9'd128 - {2'b00, blk};
    len = (rem > 16'(MAX_BURST)) ? 9'(MAX_BURST) : rem[8:0];
    if (len > bnd) len = bnd;
    return len;
  endfunction

  assign cmd_take   = cmd_valid_in & cmd_rdy_out & (cmd_words_in != 16'd0);
  assign issue_fire = rd_info_valid_out & rd_info_rdy_in;
  assign out_fire   = ref_valid_out & ref_rdy_in;
  assign req_beats  = {1'b0, rd_len_out} + 9'd1;

  assign ptr_addr_nxt = issue_fire ? ptr_addr + (ADDR_WIDTH'(req_beats) << 5) : ptr_addr;
  assign ptr_rem_nxt  = issue_fire ? ptr_rem - 16'(req_beats) : ptr_rem;
  assign next_len     = calc_len(ptr_addr_nxt[11:5], ptr_rem_nxt);

  always_comb begin
    outstanding_nxt = outstanding;
    if (issue_fire) outstanding_nxt = outstanding_nxt + CNT_W'(req_beats);
    if (out_fire)   outstanding_nxt = outstanding_nxt - CNT_W'(1);
  end

  // Credits are judged against the post-update count so a request can be
  // re-armed in the same cycle as the previous handshake.
  assign credit_ok = (17'(outstanding_nxt) + 17'(next_len)) <= 17'(FIFO_DEPTH);
  assign load_req  = (state == S_ISSUE) & (~rd_info_valid_out | issue_fire) &
                     (ptr_rem_nxt != 16'd0) & credit_ok;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_take) state_nxt = S_ISSUE;
      S_ISSUE: if (issue_fire && (ptr_rem_nxt == 16'd0)) state_nxt = S_DRAIN;
      S_DRAIN: if (out_fire && ref_last_out) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy_out = rst & (state == S_IDLE);
    busy_out    = (state != S_IDLE) | ~fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_addr          <= '0;
      ptr_rem           <= '0;
      cmd_words         <= '0;
      cmd_id            <= '0;
      out_count         <= '0;
      outstanding       <= '0;
      rd_info_valid_out <= 1'b0;
      rd_addr_out       <= '0;
      rd_len_out        <= '0;
      rd_id_out         <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (cmd_take) begin
        ptr_addr  <= cmd_addr_in & ~ADDR_WIDTH'(31);
        ptr_rem   <= cmd_words_in;
        cmd_words <= cmd_words_in;
        cmd_id    <= cmd_id_in;
        out_count <= '0;
      end else begin
        ptr_addr <= ptr_addr_nxt;
        ptr_rem  <= ptr_rem_nxt;
        if (out_fire) out_count <= out_count + 16'd1;
      end
      if (load_req) begin
        rd_info_valid_out <= 1'b1;
        rd_addr_out       <= ptr_addr_nxt;
        rd_len_out        <= 8'(next_len - 9'd1);
        rd_id_out         <= cmd_id;
      end else if (issue_fire) begin
        rd_info_valid_out <= 1'b0;
      end
    end
  end

  assign fifo_full       = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty      = (fifo_count == '0);
  assign rd_data_rdy_out = rst & ~fifo_full;
  // Beats with no credit outstanding are stale (e.g. after a reset) and dropped.
  assign fifo_wr         = rd_data_valid_in & rd_data_rdy_out & (outstanding != '0);
  assign fifo_rd         = out_fire;

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= rd_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign ref_valid_out = rst & ~fifo_empty;
  assign ref_data_out  = ref_valid_out ? mem[rd_ptr] : '0;
  assign ref_last_out  = ref_valid_out & ((out_count + 16'd1) == cmd_words);

endmodule
`default_nettype wire

// File: tb/tb_ref_fetch_unit.sv
`default_nettype none
// Directed bench for ref_fetch_unit: a simple in-order arbiter responder plus
// output capture; expected requests and beats are hand-computed constants.
module tb_ref_fetch_unit;

  logic         clk;
  logic         rst;
  logic [31:0]  cmd_addr_in;
  logic [15:0]  cmd_words_in;
  logic [5:0]   cmd_id_in;
  logic         cmd_valid_in;
  logic         cmd_rdy_out;
  logic [5:0]   rd_id_out;
  logic [31:0]  rd_addr_out;
  logic [7:0]   rd_len_out;
  logic         rd_info_valid_out;
  logic         rd_info_rdy_in;
  logic [255:0] rd_data_in;
  logic         rd_data_valid_in;
  logic         rd_data_rdy_out;
  logic [255:0] ref_data_out;
  logic         ref_last_out;
  logic         ref_valid_out;
  logic         ref_rdy_in;
  logic         busy_out;

  ref_fetch_unit dut (
    .clk(clk), .rst(rst),
    .cmd_addr_in(cmd_addr_in), .cmd_words_in(cmd_words_in), .cmd_id_in(cmd_id_in),
    .cmd_valid_in(cmd_valid_in), .cmd_rdy_out(cmd_rdy_out),
    .rd_id_out(rd_id_out), .rd_addr_out(rd_addr_out), .rd_len_out(rd_len_out),
    .rd_info_valid_out(rd_info_valid_out), .rd_info_rdy_in(rd_info_rdy_in),
    .rd_data_in(rd_data_in), .rd_data_valid_in(rd_data_valid_in), .rd_data_rdy_out(rd_data_rdy_out),
    .ref_data_out(ref_data_out), .ref_last_out(ref_last_out),
    .ref_valid_out(ref_valid_out), .ref_rdy_in(ref_rdy_in), .busy_out(busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [5:0]  id;
  } req_t;

  req_t         req_q[$];
  req_t         exp_q[$];
  logic [31:0]  pend[$];
  logic [255:0] obs_data[$];
  logic         obs_last[$];
  int           stalls = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {4{a, ~a}};
  endfunction

  // Arbiter model: records requests, returns their beats in order, captures output.
  initial begin : env
    logic rdf;
    req_t r;
    rd_data_valid_in = 1'b0;
    rd_data_in       = '0;
    forever begin
      @(negedge clk);
      rdf = 1'b0;
      if (!rst) begin
        pend.delete();
      end else begin
        if (rd_info_valid_out && rd_info_rdy_in) begin
          r.addr = rd_addr_out;
          r.len  = rd_len_out;
          r.id   = rd_id_out;
          req_q.push_back(r);
          for (int k = 0; k < int'(rd_len_out) + 1; k++)
            pend.push_back(rd_addr_out + 32'(32 * k));
        end
        rdf = rd_data_valid_in && rd_data_rdy_out;
        if (rd_data_valid_in && !rd_data_rdy_out) stalls++;
        if (ref_valid_out && ref_rdy_in) begin
          obs_data.push_back(ref_data_out);
          obs_last.push_back(ref_last_out);
        end
      end
      @(posedge clk);
      #1;
      if (rdf) void'(pend.pop_front());
      if (pend.size() > 0) begin
        rd_data_valid_in = 1'b1;
        rd_data_in       = pat(pend[0]);
      end else begin
        rd_data_valid_in = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] w, input logic [5:0] id);
    logic ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_addr_in  = a;
    cmd_words_in = w;
    cmd_id_in    = id;
    cmd_valid_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_rdy_out) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid_in = 1'b0;
    check("cmd_accept", 256'(ok), 256'(1));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy_out) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 256'(done), 256'(1));
  endtask

  task automatic expect_req(input logic [31:0] a, input logic [7:0] l, input logic [5:0] id);
    req_t r;
    r.addr = a;
    r.len  = l;
    r.id   = id;
    exp_q.push_back(r);
  endtask

  task automatic check_reqs(input string tag);
    check({tag, "_req_count"}, 256'(req_q.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < req_q.size(); i++) begin
      check({tag, "_req_addr"}, 256'(req_q[i].addr), 256'(exp_q[i].addr));
      check({tag, "_req_len"},  256'(req_q[i].len),  256'(exp_q[i].len));
      check({tag, "_req_id"},   256'(req_q[i].id),   256'(exp_q[i].id));
    end
    req_q.delete();
    exp_q.delete();
  endtask

  task automatic check_out(input string tag, input logic [31:0] base, input int words);
    check({tag, "_beat_count"}, 256'(obs_data.size()), 256'(words));
    for (int i = 0; i < words && i < obs_data.size(); i++) begin
      check({tag, "_data"}, obs_data[i], pat(base + 32'(32 * i)));
      check({tag, "_last"}, 256'(obs_last[i]), 256'(i == words - 1));
    end
    obs_data.delete();
    obs_last.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"},    256'(cmd_rdy_out), 256'(0));
    check({tag, "_info_valid"}, 256'(rd_info_valid_out), 256'(0));
    check({tag, "_ref_valid"},  256'(ref_valid_out), 256'(0));
    check({tag, "_ref_last"},   256'(ref_last_out), 256'(0));
    check({tag, "_busy"},       256'(busy_out), 256'(0));
    check({tag, "_rd_addr"},    256'(rd_addr_out), 256'(0));
    check({tag, "_rd_len"},     256'(rd_len_out), 256'(0));
    check({tag, "_rd_id"},      256'(rd_id_out), 256'(0));
    check({tag, "_ref_data"},   ref_data_out, 256'(0));
    check({tag, "_data_rdy"},   256'(rd_data_rdy_out), 256'(0));
  endtask

  initial begin : main
    logic seen;
    rst            = 1'b0;
    cmd_addr_in    = '0;
    cmd_words_in   = '0;
    cmd_id_in      = '0;
    cmd_valid_in   = 1'b0;
    rd_info_rdy_in = 1'b1;
    ref_rdy_in     = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_rdy",  256'(cmd_rdy_out), 256'(1));
    check("post_reset_data_rdy", 256'(rd_data_rdy_out), 256'(1));

    // Single aligned burst
    send_cmd(32'h1000, 16'd16, 6'h11);
    wait_idle("t1_idle", 200);
    expect_req(32'h1000, 8'd15, 6'h11);
    check_reqs("t1");
    check_out("t1", 32'h1000, 16);

    // Three bursts, last one short
    send_cmd(32'h0000, 16'd40, 6'h12);
    wait_idle("t2_idle", 300);
    expect_req(32'h0000, 8'd15, 6'h12);
    expect_req(32'h0200, 8'd15, 6'h12);
    expect_req(32'h0400, 8'd7,  6'h12);
    check_reqs("t2");
    check_out("t2", 32'h0000, 40);

    // 4 KB boundary split
    send_cmd(32'h0FC0, 16'd10, 6'h13);
    wait_idle("t3_idle", 200);
    expect_req(32'h0FC0, 8'd1, 6'h13);
    expect_req(32'h1000, 8'd7, 6'h13);
    check_reqs("t3");
    check_out("t3", 32'h0FC0, 10);

    // Output backpressure limits issue to FIFO credit
    @(posedge clk);
    #1 ref_rdy_in = 1'b0;
    send_cmd(32'h2000, 16'd64, 6'h14);
    repeat (80) @(negedge clk);
    #1;
    check("t4_stalled_reqs",   256'(req_q.size()), 256'(2));
    check("t4_info_valid_low", 256'(rd_info_valid_out), 256'(0));
    check("t4_no_output",      256'(obs_data.size()), 256'(0));
    check("t4_hold_valid",     256'(ref_valid_out), 256'(1));
    check("t4_hold_data",      ref_data_out, pat(32'h2000));
    check("t4_hold_last",      256'(ref_last_out), 256'(0));
    @(posedge clk);
    #1 ref_rdy_in = 1'b1;
    wait_idle("t4_idle", 600);
    expect_req(32'h2000, 8'd15, 6'h14);
    expect_req(32'h2200, 8'd15, 6'h14);
    expect_req(32'h2400, 8'd15, 6'h14);
    expect_req(32'h2600, 8'd15, 6'h14);
    check_reqs("t4");
    check("t4_data_rdy_stalls", 256'(stalls), 256'(0));
    check_out("t4", 32'h2000, 64);

    // Zero-length command is discarded, then a single-beat command
    send_cmd(32'h3000, 16'd0, 6'h15);
    repeat (5) @(negedge clk);
    #1;
    check("t5_cmd_rdy",   256'(cmd_rdy_out), 256'(1));
    check("t5_busy",      256'(busy_out), 256'(0));
    check("t5_no_req",    256'(req_q.size()), 256'(0));
    check("t5_no_output", 256'(obs_data.size()), 256'(0));
    send_cmd(32'h0040, 16'd1, 6'h16);
    wait_idle("t5_idle", 100);
    expect_req(32'h0040, 8'd0, 6'h16);
    check_reqs("t5");
    check_out("t5", 32'h0040, 1);

    // Reset pulse in the middle of issuing
    send_cmd(32'h0000, 16'd40, 6'h17);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (req_q.size() >= 1) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_first_req", 256'(seen), 256'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t6_in_reset");
    req_q.delete();
    obs_data.delete();
    obs_last.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_cmd_rdy", 256'(cmd_rdy_out), 256'(1));
    check("t6_busy",    256'(busy_out), 256'(0));
    repeat (10) @(negedge clk);
    #1;
    check("t6_no_partial_out", 256'(obs_data.size()), 256'(0));
    check("t6_no_partial_req", 256'(req_q.size()), 256'(0));
    // Unaligned address: low five bits are ignored
    send_cmd(32'h5007, 16'd20, 6'h18);
    wait_idle("t6_idle", 200);
    expect_req(32'h5000, 8'd15, 6'h18);
    expect_req(32'h5200, 8'd3,  6'h18);
    check_reqs("t6");
    check_out("t6", 32'h5000, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ref_fetch_unit.md
# ref_fetch_unit

Reference-sequence fetch stage sitting directly upstream of the AXI arbiter read port used by the alignment engine. Accepts a fetch command (32-byte-aligned DDR3 byte address, length in 256-bit words) and splits it into arbiter read requests of at most `MAX_BURST` beats that never cross a 4 KB boundary. It buffers returned data in a credit-protected FIFO and streams it out in order, flagging the final word. Keeps the engine free of burst, boundary and flow-control bookkeeping.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 256, beat width (32 bytes)
- `ID_WIDTH`, 6, request ID width
- `MAX_BURST`, 16, max beats per request (power of two, ≤128)
- `FIFO_DEPTH`, 32, data buffer depth in beats (power of two, ≥`MAX_BURST`)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `cmd_addr_in`  in  ADDR_WIDTH  start byte address; bits [4:0] ignored (treated as 0)
- `cmd_words_in`  in  16  number of beats to fetch
- `cmd_id_in`  in  ID_WIDTH  ID placed on every request of this command
- `cmd_valid_in` / `cmd_rdy_out`  in / out  1  command handshake
- `rd_id_out`  out  ID_WIDTH  request ID
- `rd_addr_out`  out  ADDR_WIDTH  request byte address
- `rd_len_out`  out  8  beats−1 (AXI convention)
- `rd_info_valid_out` / `rd_info_rdy_in`  out / in  1  request handshake
- `rd_data_in`  in  DATA_WIDTH  returned beat
- `rd_data_valid_in` / `rd_data_rdy_out`  in / out  1  data handshake
- `ref_data_out`  out  DATA_WIDTH  output beat
- `ref_last_out`  out  1  high on the final beat of a command
- `ref_valid_out` / `ref_rdy_in`  out / in  1  output handshake
- `busy_out`  out  1  high when state ≠ IDLE or FIFO non-empty

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: `cmd_rdy_out`=1. On `cmd_valid_in`: latch the address with [4:0] cleared, the word count and the ID. If words=0, discard the command and stay in IDLE. Otherwise go to ISSUE.
- ISSUE: compute `len` = min(remaining, `MAX_BURST`, 128 − addr[11:5]).
  - Assert the request only when outstanding + `len` ≤ `FIFO_DEPTH`. Outstanding = beats requested but not yet accepted on the output.
  - On `rd_info_valid_out & rd_info_rdy_in`: addr += len·32, remaining −= len, outstanding += len.
  - When remaining becomes 0, go to DRAIN.
- DRAIN: no requests. When the beat with `ref_last_out` is accepted, go to IDLE. The next command may then be accepted in the following cycle.
- Request-side rules:
  - `rd_id_out` = latched ID for every request.
  - Data returns in order; no reordering is done.
- Output and FIFO:
  - `ref_last_out` is asserted when the output beat count equals `cmd_words`.
  - `rd_data_rdy_out` = FIFO not full. The credit scheme guarantees it never deasserts under legal traffic.
  - A beat arriving with outstanding = 0 is accepted and dropped.
- Credits: an issue (+len) and an output acceptance (−1) in the same cycle both apply (net len−1). The counter width is log2(FIFO_DEPTH)+1.
- FIFO full and empty with simultaneous write and read: full allows a read only; empty allows a write with the read observed next cycle.

## Timing
- Reset: `cmd_rdy_out`, `rd_info_valid_out`, `ref_valid_out`, `ref_last_out` and `busy_out` are 0. `rd_addr_out`, `rd_len_out`, `rd_id_out` and `ref_data_out` are 0. `rd_data_rdy_out` is 0 while `rst`=0 and 1 after release.
- Reset mid-operation: state returns to IDLE, the FIFO and counters clear, and no partial output follows.
- `cmd_rdy_out` is high in the first cycle after reset release.
- Requests:
  - `rd_info_valid_out` is registered and rises one cycle after entry to ISSUE (or after credits permit).
  - Once high, addr/len/id are held stable until the handshake.
  - Back-to-back requests are possible: a new request is valid the cycle after the previous handshake.
- Data latency: a beat accepted on `rd_data_*` at cycle N is valid on `ref_*` at N+1 if the FIFO was empty.
- Throughput: 1 beat/cycle sustained with `ref_rdy_in`=1.
- Output `ref_*` holds stable while valid and not ready.

## Test plan
- Command addr=0x1000, words=16 → one request (0x1000, len 15); 16 output beats in order; `ref_last_out` only on the 16th; returns to IDLE.
- addr=0x0000, words=40 → requests (0x0000,15), (0x0200,15), (0x0400,7); 40 beats out, last on the 40th.
- 4 KB crossing: addr=0x0FC0, words=10 → requests (0x0FC0,1), (0x1000,7).
- Backpressure: words=64, `ref_rdy_in`=0 → exactly two 16-beat requests issued, then `rd_info_valid_out` stays 0. `rd_data_rdy_out` never deasserts. Releasing ready resumes issue; all 64 beats arrive in order.
- words=0 → no request, `cmd_rdy_out` stays 1, no output; the following addr=0x40, words=1 command → request (0x40,0), single beat with last.
- Reset pulse mid-ISSUE (after the first request of a 40-word command) → all outputs 0 during reset; IDLE with `cmd_rdy_out`=1 after release; a fresh command completes correctly.
